// File: rtl/fifo_ptr_pkg.sv
// Pointer helpers shared by the dual-clock FIFO write- and read-pointer blocks.
// Functions work on zero-extended vectors, so one copy serves every pointer width.
package fifo_ptr_pkg;

   localparam int FIFO_DROP_CNT_W = 8;
   localparam int FIFO_PTR_MAX_W  = 32;

   typedef logic [FIFO_PTR_MAX_W-1:0] ptr_wide_t;

   function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
      return b ^ (b >> 1);
   endfunction

   // Leading zeros of a zero-extended pointer leave the prefix XOR untouched.
   function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
      ptr_wide_t b;
      b = '0;
      b[FIFO_PTR_MAX_W-1] = g[FIFO_PTR_MAX_W-1];
      for (int i = FIFO_PTR_MAX_W-2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/wptr_full_level_gray2bin_conv.sv
// Combinational Gray-to-binary prefix-XOR converter; zero latency, no flow control.
module gray2bin_conv #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end

endmodule

// File: rtl/wptr_full_level.sv
// Write-side FIFO pointer, full/almost-full, fill level and (WPTR_OVF_EN) sticky overflow.
// Outputs register on the accepting edge; writes while full are dropped, pointers hold.
module wptr_full_level
   import fifo_ptr_pkg::*;
#(
   parameter int ADDRSIZE = 4,
   parameter int LVLW     = ADDRSIZE + 1
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                winc,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   input  logic [ADDRSIZE:0]   wafull_th,
   input  logic                wovf_clr,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                wafull,
   output logic [LVLW-1:0]     wlevel,
   output logic                wovf
);

   localparam int PW = ADDRSIZE + 1;

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbinnext;
   logic [PW-1:0] wgraynext;
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] wlevel_next;
   logic [PW-1:0] th_eff;
   logic          wen;
   logic          wfull_val;
   logic          wafull_next;

   assign wen       = winc & ~wfull;
   assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
   assign wgraynext = PW'(bin2gray(FIFO_PTR_MAX_W'(wbinnext)));

   gray2bin_conv #(.W(PW)) u_rptr_conv (
      .gray (wq2_rptr),
      .bin  (rbin_s)
   );

   // One full wrap ahead in Gray: top two bits inverted, the rest equal.
   assign wfull_val   = (wgraynext == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});
   assign wlevel_next = wbinnext - rbin_s;
   assign th_eff      = (wafull_th == '0) ? PW'(1) : wafull_th;
   assign wafull_next = (wlevel_next >= th_eff);

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin   <= '0;
         wptr   <= '0;
         wfull  <= 1'b0;
         wafull <= 1'b0;
         wlevel <= '0;
      end else begin
         wbin   <= wbinnext;
         wptr   <= wgraynext;
         wfull  <= wfull_val;
         wafull <= wafull_next;
         wlevel <= wlevel_next;
      end
   end

   assign waddr = wbin[ADDRSIZE-1:0];

`ifdef WPTR_OVF_EN
   logic                       ovf_evt;
   logic [FIFO_DROP_CNT_W-1:0] wdrop_cnt;

   assign ovf_evt = winc & wfull;

   // A drop in the same cycle as the clear wins, so no event is ever lost.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wovf      <= 1'b0;
         wdrop_cnt <= '0;
      end else begin
         wovf <= ovf_evt | (wovf & ~wovf_clr);
         if (wovf_clr)
            wdrop_cnt <= {{(FIFO_DROP_CNT_W-1){1'b0}}, ovf_evt};
         else if (ovf_evt && (wdrop_cnt != '1))
            wdrop_cnt <= wdrop_cnt + 1'b1;
      end
   end
`else
   logic ovf_clr_unused;

   assign ovf_clr_unused = wovf_clr;
   assign wovf           = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed scoreboard bench for wptr_full_level at ADDRSIZE=4 (depth 16).
module tb_wptr_full_level;

   logic       wclk = 1'b0;
   logic       wrst;
   logic       winc;
   logic [4:0] wq2_rptr;
   logic [4:0] wafull_th;
   logic       wovf_clr;
   logic [3:0] waddr;
   logic [4:0] wptr;
   logic       wfull;
   logic       wafull;
   logic [4:0] wlevel;
   logic       wovf;

   wptr_full_level #(.ADDRSIZE(4)) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .winc      (winc),
      .wq2_rptr  (wq2_rptr),
      .wafull_th (wafull_th),
      .wovf_clr  (wovf_clr),
      .waddr     (waddr),
      .wptr      (wptr),
      .wfull     (wfull),
      .wafull    (wafull),
      .wlevel    (wlevel),
      .wovf      (wovf)
   );

   always #5 wclk = ~wclk;

   localparam int F_WADDR = 0, F_WPTR = 1, F_WFULL = 2, F_WAFULL = 3,
                  F_WLEVEL = 4, F_WOVF = 5, F_DROP = 6;

   int    exp_fld[$];
   int    exp_val[$];
   string exp_name[$];
   int    vectors = 0;
   int    miscompares = 0;
   event  sample_ev;

   function automatic int read_field(input int fld);
      case (fld)
         F_WADDR:  return int'(waddr);
         F_WPTR:   return int'(wptr);
         F_WFULL:  return int'(wfull);
         F_WAFULL: return int'(wafull);
         F_WLEVEL: return int'(wlevel);
         F_WOVF:   return int'(wovf);
`ifdef WPTR_OVF_EN
         F_DROP:   return int'(dut.wdrop_cnt);
`endif
         default:  return -1;
      endcase
   endfunction

   task automatic drain();
      int fld, val, act;
      string nm;
      while (exp_fld.size() > 0) begin
         fld = exp_fld.pop_front();
         val = exp_val.pop_front();
         nm  = exp_name.pop_front();
         act = read_field(fld);
         vectors++;
         if (act != val) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, val, $time);
         end
      end
   endtask

   // Monitor: compares whatever the driver has queued each time outputs are presented.
   initial forever begin
      @(sample_ev);
      drain();
   end

   task automatic expect_f(input int fld, input int val, input string nm);
      exp_fld.push_back(fld);
      exp_val.push_back(val);
      exp_name.push_back(nm);
   endtask

   task automatic present();
      -> sample_ev;
   endtask

   function automatic logic [4:0] gray5(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   // Drive inputs for the coming edge, then land 1 time unit after it.
   task automatic step(input logic w, input logic [4:0] rg);
      winc     = w;
      wq2_rptr = rg;
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      wrst = 1'b1; winc = 1'b0; wq2_rptr = '0; wovf_clr = 1'b0;
      #3;
      wrst = 1'b0;
   endtask

   task automatic expect_all_zero(input string tag);
      expect_f(F_WADDR,  0, {tag, "_waddr"});
      expect_f(F_WPTR,   0, {tag, "_wptr"});
      expect_f(F_WFULL,  0, {tag, "_wfull"});
      expect_f(F_WAFULL, 0, {tag, "_wafull"});
      expect_f(F_WLEVEL, 0, {tag, "_wlevel"});
      expect_f(F_WOVF,   0, {tag, "_wovf"});
      present();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      wrst = 1'b1; winc = 1'b0; wq2_rptr = '0; wafull_th = 5'd12; wovf_clr = 1'b0;
      #2;
      expect_all_zero("por");
      @(posedge wclk); #1;
      wrst = 1'b0;

      // 1. reset mid-burst at level 7
      for (int i = 0; i < 7; i++) step(1'b1, 5'd0);
      expect_f(F_WLEVEL, 7, "pre_rst_level"); present();
      #2;
      wrst = 1'b1;
      #1;
      expect_all_zero("mid_rst");
      wrst = 1'b0; winc = 1'b1;
      expect_f(F_WADDR, 0, "rel_waddr0"); present();
      step(1'b1, 5'd0); expect_f(F_WADDR, 1, "rel_waddr1"); present();
      step(1'b1, 5'd0); expect_f(F_WADDR, 2, "rel_waddr2"); present();
      winc = 1'b0;

      // 2. fill to 16 with read pointer parked, threshold at full depth
      do_reset();
      wafull_th = 5'd16;
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 5'd0);
         expect_f(F_WLEVEL, i, $sformatf("fill_level%0d", i));
         expect_f(F_WFULL, (i == 16) ? 1 : 0, $sformatf("fill_full%0d", i));
         present();
      end
      expect_f(F_WPTR, 5'b11000, "fill_wptr16"); present();

      // 5. overflow: three dropped writes while full
      step(1'b1, 5'd0);
      expect_f(F_WPTR, 5'b11000, "drop_wptr_hold");
      expect_f(F_WLEVEL, 16, "drop_level_hold");
      expect_f(F_WADDR, 0, "drop_waddr_hold");
      present();
      step(1'b1, 5'd0);
      step(1'b1, 5'd0);
`ifdef WPTR_OVF_EN
      expect_f(F_WOVF, 1, "ovf_set");
      expect_f(F_DROP, 3, "drop_cnt3");
      present();
      wovf_clr = 1'b1;
      step(1'b0, 5'd0);
      expect_f(F_WOVF, 0, "ovf_clr");
      expect_f(F_DROP, 0, "drop_cnt_clr");
      present();
      step(1'b1, 5'd0);
      expect_f(F_WOVF, 1, "ovf_set_wins");
      present();
      wovf_clr = 1'b0;
`else
      expect_f(F_WOVF, 0, "ovf_tied_low"); present();
      wovf_clr = 1'b1;
      step(1'b1, 5'd0);
      expect_f(F_WOVF, 0, "ovf_clr_ignored"); present();
      wovf_clr = 1'b0;
`endif
      expect_f(F_WFULL, 1, "still_full"); present();

      // 3. almost-full at 12, cleared by two reads
      do_reset();
      wafull_th = 5'd12;
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 5'd0);
         if (i >= 11) begin
            expect_f(F_WAFULL, (i == 12) ? 1 : 0, $sformatf("afull_w%0d", i));
            present();
         end
      end
      step(1'b0, gray5(2));
      expect_f(F_WLEVEL, 10, "afull_level10");
      expect_f(F_WAFULL, 0, "afull_fall");
      present();

      // zero threshold behaves as one
      do_reset();
      wafull_th = 5'd0;
      step(1'b0, 5'd0);
      expect_f(F_WAFULL, 0, "th0_empty"); present();
      step(1'b1, 5'd0);
      expect_f(F_WAFULL, 1, "th0_one_word"); present();

      // 4. wrap-around streaming with reads trailing by 3
      do_reset();
      wafull_th = 5'd16;
      for (int k = 1; k <= 40; k++) begin
         step(1'b1, (k >= 3) ? gray5(k - 3) : 5'd0);
         expect_f(F_WLEVEL, (k >= 3) ? 3 : k, $sformatf("wrap_level%0d", k));
         expect_f(F_WFULL, 0, $sformatf("wrap_full%0d", k));
         present();
      end
      expect_f(F_WADDR, 8, "wrap_waddr40");
      expect_f(F_WPTR, int'(5'b01100), "wrap_wptr40");
      present();

      // 6. write plus read advance at level 8
      do_reset();
      wafull_th = 5'd8;
      for (int i = 0; i < 8; i++) step(1'b1, 5'd0);
      expect_f(F_WLEVEL, 8, "sim_level_pre");
      expect_f(F_WAFULL, 1, "sim_afull_pre");
      present();
      step(1'b1, gray5(1));
      expect_f(F_WLEVEL, 8, "sim_level_post");
      expect_f(F_WAFULL, 1, "sim_afull_post");
      expect_f(F_WADDR, 9, "sim_waddr_post");
      present();
      winc = 1'b0;

      #1;
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
